// File: rtl/riscv_div_unit_pkg.sv
// Shared definitions for the iterative RV32M divide unit:
// op encodings (funct3[1:0]), FSM state encoding and small decode helpers.
package riscv_div_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  // funct3[0]=0 selects the signed flavour (DIV/REM)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // funct3[1]=1 selects the remainder flavour (REM/REMU)
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/riscv_div_unit_if.sv
// Request/response bundle between the execute stage and the divide unit.
// master = pipeline side, slave = divide unit.
interface riscv_div_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic            kill;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, kill, op, rs1, rs2, input busy, done, result);
  modport slave  (input start, kill, op, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/riscv_div_step.sv
// One radix-2 restoring iteration: shift {rem,quot} left by one, trial-subtract
// the divisor from the widened partial remainder and keep the difference when
// it is non-negative. The partial remainder is always below the divisor, so the
// XLEN+1-bit difference's top bit is a reliable sign.
module riscv_div_step #(parameter int XLEN = 32) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quot_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quot_out
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // shift in the next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    shifted = {rem_in, quot_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_out  = diff[XLEN-1:0];
      quot_out = {quot_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out  = shifted[XLEN-1:0];
      quot_out = {quot_in[XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/riscv_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Signed ops run on magnitudes and fix the signs in FIX. Divide-by-zero and
// signed overflow complete in one cycle straight from IDLE.
// Optional: define DIV_EARLY_OUT_EN to also finish in one cycle when the
// divisor magnitude exceeds the dividend magnitude (quotient 0, remainder rs1).
module riscv_div_unit
  import riscv_div_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 6
) (
  input logic             clk,
  input logic             rst,
  riscv_div_unit_if.slave bus
);
  div_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]      op_q;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] rem_q, quot_q, dvsr_q, result_q;
  logic [XLEN-1:0] rem_step, quot_step;

  logic            in_signed, in_rem, accept;
  logic            div_zero, ovf, early, special;
  logic [XLEN-1:0] abs_a, abs_b, special_res;
  logic [XLEN-1:0] fix_quot, fix_rem, fixed_res;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  riscv_div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quot_in (quot_q),
    .divisor (dvsr_q),
    .rem_out (rem_step),
    .quot_out(quot_step)
  );

  // request decode: operand magnitudes and single-cycle special cases
  always_comb begin
    in_signed = op_is_signed(bus.op);
    in_rem    = op_is_rem(bus.op);
    accept    = (state == ST_IDLE) && bus.start && !bus.kill;
    abs_a     = (in_signed && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
    abs_b     = (in_signed && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
    div_zero  = (bus.rs2 == '0);
    ovf       = in_signed && (bus.rs1 == INT_MIN) && (bus.rs2 == '1);
`ifdef DIV_EARLY_OUT_EN
    early     = (abs_b > abs_a);
`else
    early     = 1'b0;
`endif
    special   = div_zero || ovf || early;
    if (div_zero)  special_res = in_rem ? bus.rs1 : '1;
    else if (ovf)  special_res = in_rem ? '0 : INT_MIN;
    else           special_res = in_rem ? bus.rs1 : '0;
  end

  // sign fix-up of the unsigned core result
  always_comb begin
    fix_quot  = (neg_a ^ neg_b) ? -quot_q : quot_q;
    fix_rem   = neg_a ? -rem_q : rem_q;
    fixed_res = op_is_rem(op_q) ? fix_rem : fix_quot;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic; kill aborts any operation in flight
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = special ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (bus.kill && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  // FSM outputs
  always_comb begin
    bus.busy = (state == ST_CALC) || (state == ST_FIX);
    bus.done = (state == ST_DONE) && !bus.kill;
  end

  assign bus.result = result_q;

  // operand latch, iteration datapath, counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          op_q   <= bus.op;
          neg_a  <= in_signed && bus.rs1[XLEN-1];
          neg_b  <= in_signed && bus.rs2[XLEN-1];
          rem_q  <= '0;
          quot_q <= abs_a;
          dvsr_q <= abs_b;
          cnt    <= CNT_W'(XLEN-1);
          if (special) result_q <= special_res;
        end
        ST_CALC: if (!bus.kill) begin
          rem_q  <= rem_step;
          quot_q <= quot_step;
          cnt    <= cnt - CNT_W'(1);
        end
        ST_FIX: if (!bus.kill) result_q <= fixed_res;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed self-checking bench for riscv_div_unit: latency, quotient/remainder
// values, special cases, kill, ignored starts and mid-operation reset.
module tb_riscv_div_unit;
  import riscv_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_EO = 1;
`else
  localparam int LAT_EO = 34;
`endif

  riscv_div_unit_if #(.XLEN(32)) bus ();

  riscv_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // issue one op with start in cycle 0; lat = cycle index where done is seen (-1 if never)
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs1 = a; bus.rs2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1; res = 'x;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.done) begin lat = c; res = bus.result; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [1:0]  ops [2] = '{DIV_OP_DIVU, DIV_OP_REMU};
    logic [31:0] exp [2] = '{32'd14, 32'd2};
    int lat; logic [31:0] res;
    for (int i = 0; i < 2; i++) begin
      run_op(ops[i], 32'd100, 32'd7, lat, res);
      checks++; if (lat !== 34) begin errors++; $display("FAIL unsigned_lat[%0d]: got %0d want 34", i, lat); end
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL unsigned_res[%0d]: got %h want %h", i, res, exp[i]); end
    end
  endtask

  task automatic test_signed();
    logic [1:0]  ops [4] = '{DIV_OP_DIV, DIV_OP_REM, DIV_OP_REM, DIV_OP_DIV};
    logic [31:0] a   [4] = '{32'hFFFFFF9C, 32'hFFFFFF9C, 32'd100, 32'd100};
    logic [31:0] b   [4] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] exp [4] = '{32'hFFFFFFF2, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFF2};
    int lat; logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], a[i], b[i], lat, res);
      checks++; if (lat !== 34) begin errors++; $display("FAIL signed_lat[%0d]: got %0d want 34", i, lat); end
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL signed_res[%0d]: got %h want %h", i, res, exp[i]); end
    end
  endtask

  task automatic test_special();
    logic [1:0]  ops [4] = '{DIV_OP_DIV, DIV_OP_REMU, DIV_OP_DIV, DIV_OP_REM};
    logic [31:0] a   [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] b   [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    int lat; logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], a[i], b[i], lat, res);
      checks++; if (lat !== 1) begin errors++; $display("FAIL special_lat[%0d]: got %0d want 1", i, lat); end
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL special_res[%0d]: got %h want %h", i, res, exp[i]); end
    end
  endtask

  task automatic test_kill();
    int lat; logic [31:0] res; bit seen;
    run_op(DIV_OP_DIVU, 32'd100, 32'd7, lat, res);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL kill_prior: got %h want 0000000e", res); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIV_OP_DIV; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL kill_busy_before: got %b want 1", bus.busy); end
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL kill_busy_after: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL kill_done_after: got %b want 0", bus.done); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.done) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL kill_no_done: got %b want 0", seen); end
    checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL kill_result_held: got %h want 0000000e", bus.result); end
  endtask

  task automatic test_back_to_back();
    int lat = -1; logic [31:0] res = 'x;
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIV_OP_DIVU; bus.rs1 = 32'd50; bus.rs2 = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = DIV_OP_REMU; bus.rs1 = 32'd7; bus.rs2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 6; c <= 100; c++) begin
      @(negedge clk);
      if (bus.done) begin lat = c; res = bus.result; break; end
    end
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_lat: got %0d want 34", lat); end
    checks++; if (res !== 32'd10) begin errors++; $display("FAIL b2b_res: got %h want 0000000a", res); end
    // start presented in the DONE cycle must be dropped
    bus.start = 1'b1; bus.op = DIV_OP_DIVU; bus.rs1 = 32'd9; bus.rs2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_start_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_start_done: got %b want 0", bus.done); end
  endtask

  task automatic test_rst_mid();
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIV_OP_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.rs1 = 32'd9; bus.rs2 = 32'd3;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", bus.result); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.done) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got %b want 0", seen); end
  endtask

  task automatic test_early_out();
    logic [1:0]  ops [3] = '{DIV_OP_DIVU, DIV_OP_REM, DIV_OP_DIV};
    logic [31:0] a   [3] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD};
    logic [31:0] exp [3] = '{32'd0, 32'hFFFFFFFD, 32'd0};
    int lat; logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], a[i], 32'd10, lat, res);
      checks++; if (lat !== LAT_EO) begin errors++; $display("FAIL early_lat[%0d]: got %0d want %0d", i, lat, LAT_EO); end
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL early_res[%0d]: got %h want %h", i, res, exp[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = 2'b00; bus.rs1 = '0; bus.rs2 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_kill();
    test_back_to_back();
    test_rst_mid();
    test_early_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
